// File: rtl/slew_pkg.sv
// slew_pkg: shared types and divider presets for the multi-axis slew limiter.
package slew_pkg;
    typedef enum logic {S_IDLE, S_SCAN} scan_state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} slew_dir_t;
    localparam int TICK_DIV_50HZ = 240000;
    localparam int TICK_DIV_100HZ = 119999 + 1;
endpackage

// File: rtl/slew_tick_gen.sv
// slew_tick_gen: free-running divider, o_tick high while the count sits at TICK_DIV-1.
module slew_tick_gen #(
    parameter int TICK_DIV = 240000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);
    localparam int CW = $clog2(TICK_DIV);
    logic [CW-1:0] r_cnt;
    assign o_tick = r_cnt == CW'(TICK_DIV - 1);
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_cnt <= '0;
        else r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
endmodule

// File: rtl/multi_axis_slew_limiter.sv
// multi_axis_slew_limiter: per-tick rate limiting of NUM_CH duty channels, scanned one channel per cycle.
// Define SLEW_ACCEL_EN for per-channel step acceleration (soft start on long moves).
module multi_axis_slew_limiter import slew_pkg::*; #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 8,
    parameter int TICK_DIV   = TICK_DIV_50HZ,
    parameter int STEP_W     = 4,
    parameter int RESET_DUTY = 150,
    parameter int MIN_DUTY   = 0,
    parameter int MAX_DUTY   = 2**DATA_W - 1
) (
    input  logic                     clk_12mhz,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] target_duty,
    input  logic [STEP_W-1:0]        step_size,
    input  logic                     hold,
    input  logic                     snap,
    output logic [NUM_CH*DATA_W-1:0] actual_duty,
    output logic [NUM_CH-1:0]        settled,
    output logic                     busy,
    output logic                     tick
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int XW = DATA_W + 2;
    localparam logic signed [XW-1:0] LO_X = XW'(MIN_DUTY);
    localparam logic signed [XW-1:0] HI_X = XW'(MAX_DUTY);
    localparam logic [DATA_W-1:0] RST_V = DATA_W'(RESET_DUTY);

    scan_state_t r_state, w_state_nx;
    logic [CW-1:0] r_ch_idx, w_ch_idx_nx;
    logic w_last;

    slew_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .i_clk (clk_12mhz),
        .i_rst (reset),
        .o_tick(tick)
    );

    assign busy   = r_state == S_SCAN;
    assign w_last = r_ch_idx == CW'(NUM_CH - 1);

    always_ff @(posedge clk_12mhz or posedge reset)
        if (reset) begin
            r_state  <= S_IDLE;
            r_ch_idx <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_ch_idx <= w_ch_idx_nx;
        end

    always_comb begin
        w_state_nx  = r_state;
        w_ch_idx_nx = '0;
        if (snap) w_state_nx = S_IDLE;
        else if (r_state == S_IDLE) w_state_nx = (tick && !hold) ? S_SCAN : S_IDLE;
        else begin
            w_state_nx  = w_last ? S_IDLE : S_SCAN;
            w_ch_idx_nx = w_last ? '0 : r_ch_idx + CW'(1);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] w_raw, w_tgt, w_next, r_duty;
        logic [STEP_W-1:0] w_eff;
        logic signed [XW-1:0] w_r, w_t, w_a, w_s, w_up, w_dn;
        logic w_upd;
        // Two guard bits keep a+s and a-s from wrapping at the rails.
        assign w_raw  = target_duty[k*DATA_W +: DATA_W];
        assign w_r    = $signed({2'b00, w_raw});
        assign w_t    = w_r < LO_X ? LO_X : w_r > HI_X ? HI_X : w_r;
        assign w_tgt  = w_t[DATA_W-1:0];
        assign w_a    = $signed({2'b00, r_duty});
        assign w_s    = $signed(XW'(w_eff));
        assign w_up   = w_a + w_s;
        assign w_dn   = w_a - w_s;
        assign w_next = w_eff == '0 ? r_duty : w_t > w_up ? w_up[DATA_W-1:0] :
                        w_t < w_dn ? w_dn[DATA_W-1:0] : w_tgt;
        assign w_upd  = busy && r_ch_idx == CW'(k);
        always_ff @(posedge clk_12mhz or posedge reset)
            if (reset) r_duty <= RST_V;
            else if (snap) r_duty <= w_tgt;
            else if (w_upd) r_duty <= w_next;
        assign actual_duty[k*DATA_W +: DATA_W] = r_duty;
        assign settled[k] = r_duty == w_tgt;
`ifdef SLEW_ACCEL_EN
        slew_dir_t r_dir, w_dir;
        logic [STEP_W-1:0] r_step, w_lim;
        assign w_dir = w_t > w_a ? DIR_UP : w_t < w_a ? DIR_DOWN : DIR_NONE;
        assign w_lim = r_step > step_size ? step_size : r_step;
        assign w_eff = step_size == '0 ? '0 : w_dir == r_dir ? w_lim : STEP_W'(1);
        // r_step holds the step to use on the next move in r_dir.
        always_ff @(posedge clk_12mhz or posedge reset)
            if (reset || snap) begin
                r_dir  <= DIR_NONE;
                r_step <= STEP_W'(1);
            end else if (w_upd && w_eff != '0) begin
                r_dir  <= w_next == w_tgt ? DIR_NONE : w_dir;
                r_step <= w_next == w_tgt ? STEP_W'(1) : w_eff == step_size ? step_size : w_eff + STEP_W'(1);
            end
`else
        assign w_eff = step_size;
`endif
    end
endmodule
